wshb_arbiter: RTL and testbench
===============================

WSHB_ARBITER -- requirements
Module: wshb_arbiter

Interface
REQ-001 Parameter MAX_ACK, default 64, sets how many acknowledged transfers a master may complete before it is preempted when the other master is requesting.
REQ-002 sys_clk  input  1  system clock (100 MHz), sole clock of the block.
REQ-003 sys_rst  input  1  reset, asynchronous, active-high.
REQ-004 wshb_ifs_0  wshb_if.slave  DATA_BYTES=4  requester 0: video read master (vga), round-robin favoured after reset.
REQ-005 wshb_ifs_1  wshb_if.slave  DATA_BYTES=4  requester 1: frame writer master (pattern generator / stream copier).
REQ-006 wshb_ifm  wshb_if.master  DATA_BYTES=4  shared port to the SDRAM slave (wshb_if_sdram).
REQ-007 Signals routed: cyc, stb, we, adr, sel, dat_ms, cti, bte (master to slave); dat_sm, ack, err, rty (slave to master).

Function
REQ-008 The FSM shall have states IDLE, GNT0, GNT1, with the state register clocked by sys_clk.
REQ-009 IDLE: wshb_ifm.cyc=0, wshb_ifm.stb=0, both masters see ack=err=rty=0.
REQ-010 IDLE to GNTx on the clock edge after wshb_ifs_x.cyc=1, giving 1 cycle of arbitration latency.
REQ-011 Both cyc high in IDLE: grant the master not served last. The last-served pointer resets to 1, so master 0 wins the first tie.
REQ-012 GNTx: all master-to-slave signals of wshb_ifs_x are driven combinationally onto wshb_ifm; slave-to-master signals go to wshb_ifs_x only.
REQ-013 The non-granted master shall see ack=err=rty=0 and dat_sm=0, and stall.
REQ-014 GNTx with wshb_ifs_x.cyc=0 and the other master's cyc=1: go directly to GNTy with no IDLE cycle.
REQ-015 GNTx with wshb_ifs_x.cyc=0 and the other master's cyc=0: go to IDLE.
REQ-016 Ack counter, width $clog2(MAX_ACK+1):
 - cleared on every grant change;
 - incremented on each cycle with wshb_ifm.ack=1 and state GNTx.
REQ-017 Preemption: in a cycle where the counter reaches MAX_ACK with ack=1 and the other cyc=1, the next state shall be GNTy.
 - The preempted master keeps cyc high and sees no ack until it is re-granted.
 - The slave sees cyc drop for at least 0 cycles: a direct handover is legal because stb/adr switch atomically at a transfer boundary.
REQ-018 Preemption shall never occur mid-transfer: switching happens only on the edge after an ack, err or rty cycle, or when cyc=0.
REQ-019 err and rty count as transfer terminations for REQ-018 but shall not increment the counter.
REQ-020 The counter shall saturate at MAX_ACK when there is no competing request, with no wrap-around.
REQ-021 A simultaneous cyc drop of the granted master and cyc rise of the other master is handled per REQ-014.
REQ-022 Output grant_o[1:0] (one-hot, registered, debug) shall reflect the state: 00 in IDLE.

Reset
REQ-023 sys_rst=1 shall asynchronously force state=IDLE, counter=0, last-served=1, grant_o=00, wshb_ifm.cyc=stb=0, and all master acks=0.
REQ-024 Reset asserted mid-transfer shall drop wshb_ifm.cyc in the same cycle. No transfer state is retained after deassertion.

Structure
REQ-025 Package wshb_arb_pkg shall hold the typedef enum logic [1:0] {IDLE,GNT0,GNT1} arb_state_t and the MAX_ACK default constant.
REQ-026 The block shall have no sub-module. The mux shall be one always_comb block selected by state, and the next-state logic a separate always_comb block.

Verification
REQ-027 Master 0 alone issues an 8-word read burst at adr 0x0000_0000 -> grant on cycle 2, 8 acks routed to master 0, and IDLE 1 cycle after cyc drops.
REQ-028 Both cyc rise on the same edge after reset -> GNT0 first. After master 0 drops cyc, direct handover to GNT1 with no IDLE cycle.
REQ-029 MAX_ACK=4, master 0 streams continuously, master 1 requests -> after the 4th ack, the next cycle is GNT1. Master 0 sees ack=0 while its cyc stays 1, then resumes after master 1 releases.
REQ-030 Slave returns err on master 1's 2nd transfer -> err reaches master 1 only, the counter stays unchanged, and the grant holds.
REQ-031 sys_rst pulsed for 1 cycle during a GNT1 burst -> wshb_ifm.cyc=0 within the same cycle, state IDLE, and master 0 wins the next tie.
REQ-032 A random two-master stress test of 10k cycles with a scoreboard shall confirm:
 - no ack to a non-granted master;
 - no adr/dat change at the slave except at transfer boundaries;
 - every request is granted within 2*MAX_ACK+2 transfers.

Source files
------------

// File: rtl/wshb_arb_pkg.sv
// Shared types and defaults for the two-master Wishbone arbiter.
package wshb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_t;

    localparam int MAX_ACK_DEFAULT = 64;

endpackage

// File: rtl/wshb_arbiter.sv
// Two-master Wishbone arbiter in front of the SDRAM slave: round-robin on ties,
// ack-quota preemption at transfer boundaries, direct handover between masters.
module wshb_arbiter
    import wshb_arb_pkg::*;
#(
    parameter int MAX_ACK = MAX_ACK_DEFAULT
) (
    input  logic        sys_clk,
    input  logic        sys_rst,

    input  logic        wshb_ifs_0_cyc,
    input  logic        wshb_ifs_0_stb,
    input  logic        wshb_ifs_0_we,
    input  logic [31:0] wshb_ifs_0_adr,
    input  logic [3:0]  wshb_ifs_0_sel,
    input  logic [31:0] wshb_ifs_0_dat_ms,
    input  logic [2:0]  wshb_ifs_0_cti,
    input  logic [1:0]  wshb_ifs_0_bte,
    output logic [31:0] wshb_ifs_0_dat_sm,
    output logic        wshb_ifs_0_ack,
    output logic        wshb_ifs_0_err,
    output logic        wshb_ifs_0_rty,

    input  logic        wshb_ifs_1_cyc,
    input  logic        wshb_ifs_1_stb,
    input  logic        wshb_ifs_1_we,
    input  logic [31:0] wshb_ifs_1_adr,
    input  logic [3:0]  wshb_ifs_1_sel,
    input  logic [31:0] wshb_ifs_1_dat_ms,
    input  logic [2:0]  wshb_ifs_1_cti,
    input  logic [1:0]  wshb_ifs_1_bte,
    output logic [31:0] wshb_ifs_1_dat_sm,
    output logic        wshb_ifs_1_ack,
    output logic        wshb_ifs_1_err,
    output logic        wshb_ifs_1_rty,

    output logic        wshb_ifm_cyc,
    output logic        wshb_ifm_stb,
    output logic        wshb_ifm_we,
    output logic [31:0] wshb_ifm_adr,
    output logic [3:0]  wshb_ifm_sel,
    output logic [31:0] wshb_ifm_dat_ms,
    output logic [2:0]  wshb_ifm_cti,
    output logic [1:0]  wshb_ifm_bte,
    input  logic [31:0] wshb_ifm_dat_sm,
    input  logic        wshb_ifm_ack,
    input  logic        wshb_ifm_err,
    input  logic        wshb_ifm_rty,

    output logic [1:0]  grant_o
);

    localparam int CW = $clog2(MAX_ACK + 1);
    localparam logic [CW-1:0] ACK_LIMIT = CW'(MAX_ACK);

    arb_state_t    state, state_next;
    logic          last_served;
    logic [CW-1:0] ack_cnt, ack_cnt_inc;
    logic          term, quota_done;

    always_comb begin
        term        = wshb_ifm_ack | wshb_ifm_err | wshb_ifm_rty;
        ack_cnt_inc = (wshb_ifm_ack && (ack_cnt != ACK_LIMIT)) ? ack_cnt + 1'b1 : ack_cnt;
        // quota is judged on the count including this cycle's ack, and only at a boundary
        quota_done  = term && (ack_cnt_inc == ACK_LIMIT);
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (wshb_ifs_0_cyc && wshb_ifs_1_cyc)
                    state_next = last_served ? GNT0 : GNT1;
                else if (wshb_ifs_0_cyc)
                    state_next = GNT0;
                else if (wshb_ifs_1_cyc)
                    state_next = GNT1;
            end
            GNT0: begin
                if (!wshb_ifs_0_cyc)
                    state_next = wshb_ifs_1_cyc ? GNT1 : IDLE;
                else if (wshb_ifs_1_cyc && quota_done)
                    state_next = GNT1;
            end
            GNT1: begin
                if (!wshb_ifs_1_cyc)
                    state_next = wshb_ifs_0_cyc ? GNT0 : IDLE;
                else if (wshb_ifs_0_cyc && quota_done)
                    state_next = GNT0;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state       <= IDLE;
            ack_cnt     <= '0;
            last_served <= 1'b1;
            grant_o     <= 2'b00;
        end else begin
            state <= state_next;
            if (state_next != state)
                ack_cnt <= '0;
            else if (state != IDLE)
                ack_cnt <= ack_cnt_inc;
            if (state_next == GNT0)
                last_served <= 1'b0;
            else if (state_next == GNT1)
                last_served <= 1'b1;
            grant_o <= {state_next == GNT1, state_next == GNT0};
        end
    end

    always_comb begin
        wshb_ifm_cyc      = 1'b0;
        wshb_ifm_stb      = 1'b0;
        wshb_ifm_we       = 1'b0;
        wshb_ifm_adr      = '0;
        wshb_ifm_sel      = '0;
        wshb_ifm_dat_ms   = '0;
        wshb_ifm_cti      = '0;
        wshb_ifm_bte      = '0;
        wshb_ifs_0_dat_sm = '0;
        wshb_ifs_0_ack    = 1'b0;
        wshb_ifs_0_err    = 1'b0;
        wshb_ifs_0_rty    = 1'b0;
        wshb_ifs_1_dat_sm = '0;
        wshb_ifs_1_ack    = 1'b0;
        wshb_ifs_1_err    = 1'b0;
        wshb_ifs_1_rty    = 1'b0;
        case (state)
            GNT0: begin
                wshb_ifm_cyc      = wshb_ifs_0_cyc;
                wshb_ifm_stb      = wshb_ifs_0_stb;
                wshb_ifm_we       = wshb_ifs_0_we;
                wshb_ifm_adr      = wshb_ifs_0_adr;
                wshb_ifm_sel      = wshb_ifs_0_sel;
                wshb_ifm_dat_ms   = wshb_ifs_0_dat_ms;
                wshb_ifm_cti      = wshb_ifs_0_cti;
                wshb_ifm_bte      = wshb_ifs_0_bte;
                wshb_ifs_0_dat_sm = wshb_ifm_dat_sm;
                wshb_ifs_0_ack    = wshb_ifm_ack;
                wshb_ifs_0_err    = wshb_ifm_err;
                wshb_ifs_0_rty    = wshb_ifm_rty;
            end
            GNT1: begin
                wshb_ifm_cyc      = wshb_ifs_1_cyc;
                wshb_ifm_stb      = wshb_ifs_1_stb;
                wshb_ifm_we       = wshb_ifs_1_we;
                wshb_ifm_adr      = wshb_ifs_1_adr;
                wshb_ifm_sel      = wshb_ifs_1_sel;
                wshb_ifm_dat_ms   = wshb_ifs_1_dat_ms;
                wshb_ifm_cti      = wshb_ifs_1_cti;
                wshb_ifm_bte      = wshb_ifs_1_bte;
                wshb_ifs_1_dat_sm = wshb_ifm_dat_sm;
                wshb_ifs_1_ack    = wshb_ifm_ack;
                wshb_ifs_1_err    = wshb_ifm_err;
                wshb_ifs_1_rty    = wshb_ifm_rty;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_wshb_arbiter.sv
// Directed and random checks of the two-master Wishbone arbiter with a zero-wait slave model.
module tb_wshb_arbiter;

    localparam int MAX_ACK = 4;
    localparam logic [31:0] DMASK = 32'hA5A5_0000;

    logic        sys_clk = 1'b0;
    logic        sys_rst;

    logic        c0, st0, we0, c1, st1, we1;
    logic [31:0] a0, d0, a1, d1;
    logic [3:0]  sel0, sel1;
    logic [2:0]  cti0, cti1;
    logic [1:0]  bte0, bte1;
    logic [31:0] dsm0, dsm1;
    logic        ack0, err0, rty0, ack1, err1, rty1;

    logic        m_cyc, m_stb, m_we;
    logic [31:0] m_adr, m_dat_ms, m_dat_sm;
    logic [3:0]  m_sel;
    logic [2:0]  m_cti;
    logic [1:0]  m_bte;
    logic        m_ack, m_err, m_rty;
    logic [1:0]  grant_o;

    logic        ack_en, err_on;
    int          total = 0;
    int          bad = 0;

    always #5 sys_clk = ~sys_clk;

    // zero-wait slave: read data is a function of the address
    assign m_ack    = m_cyc & m_stb & ack_en & ~err_on;
    assign m_err    = m_cyc & m_stb & err_on;
    assign m_rty    = 1'b0;
    assign m_dat_sm = m_adr ^ DMASK;

    wshb_arbiter #(.MAX_ACK(MAX_ACK)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .wshb_ifs_0_cyc(c0), .wshb_ifs_0_stb(st0), .wshb_ifs_0_we(we0), .wshb_ifs_0_adr(a0),
        .wshb_ifs_0_sel(sel0), .wshb_ifs_0_dat_ms(d0), .wshb_ifs_0_cti(cti0), .wshb_ifs_0_bte(bte0),
        .wshb_ifs_0_dat_sm(dsm0), .wshb_ifs_0_ack(ack0), .wshb_ifs_0_err(err0), .wshb_ifs_0_rty(rty0),
        .wshb_ifs_1_cyc(c1), .wshb_ifs_1_stb(st1), .wshb_ifs_1_we(we1), .wshb_ifs_1_adr(a1),
        .wshb_ifs_1_sel(sel1), .wshb_ifs_1_dat_ms(d1), .wshb_ifs_1_cti(cti1), .wshb_ifs_1_bte(bte1),
        .wshb_ifs_1_dat_sm(dsm1), .wshb_ifs_1_ack(ack1), .wshb_ifs_1_err(err1), .wshb_ifs_1_rty(rty1),
        .wshb_ifm_cyc(m_cyc), .wshb_ifm_stb(m_stb), .wshb_ifm_we(m_we), .wshb_ifm_adr(m_adr),
        .wshb_ifm_sel(m_sel), .wshb_ifm_dat_ms(m_dat_ms), .wshb_ifm_cti(m_cti), .wshb_ifm_bte(m_bte),
        .wshb_ifm_dat_sm(m_dat_sm), .wshb_ifm_ack(m_ack), .wshb_ifm_err(m_err), .wshb_ifm_rty(m_rty),
        .grant_o(grant_o)
    );

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        tick();
        tick();
        total++; if (grant_o !== 2'b00) begin bad++; $display("FAIL reset_grant: got %b want 00", grant_o); end
        total++; if (m_cyc !== 1'b0) begin bad++; $display("FAIL reset_cyc: got %b want 0", m_cyc); end
        total++; if (m_stb !== 1'b0) begin bad++; $display("FAIL reset_stb: got %b want 0", m_stb); end
        total++; if ({ack0, ack1} !== 2'b00) begin bad++; $display("FAIL reset_acks: got %b want 00", {ack0, ack1}); end
        sys_rst = 1'b0;
    endtask

    task automatic test_single_burst();
        c0 = 1; st0 = 1; a0 = 32'h0000_0000; cti0 = 3'b010;
        settle();
        total++; if (grant_o !== 2'b00) begin bad++; $display("FAIL burst_cycle1_grant: got %b want 00", grant_o); end
        total++; if (m_cyc !== 1'b0) begin bad++; $display("FAIL burst_cycle1_cyc: got %b want 0", m_cyc); end
        tick();
        total++; if (grant_o !== 2'b01) begin bad++; $display("FAIL burst_cycle2_grant: got %b want 01", grant_o); end
        for (int i = 0; i < 8; i++) begin
            settle();
            total++; if ({ack0, ack1} !== 2'b10) begin bad++; $display("FAIL burst_ack[%0d]: got %b want 10", i, {ack0, ack1}); end
            total++; if (m_adr !== 32'(i * 4)) begin bad++; $display("FAIL burst_adr[%0d]: got %h want %h", i, m_adr, 32'(i * 4)); end
            total++; if (dsm0 !== (32'(i * 4) ^ DMASK)) begin bad++; $display("FAIL burst_dat[%0d]: got %h want %h", i, dsm0, 32'(i * 4) ^ DMASK); end
            tick();
            a0 = a0 + 4;
            if (i == 7) begin c0 = 0; st0 = 0; cti0 = 3'b000; end
        end
        settle();
        total++; if (m_cyc !== 1'b0) begin bad++; $display("FAIL burst_drop_cyc: got %b want 0", m_cyc); end
        tick();
        total++; if (grant_o !== 2'b00) begin bad++; $display("FAIL burst_idle: got %b want 00", grant_o); end
    endtask

    task automatic test_tie();
        do_reset();
        c0 = 1; st0 = 1; a0 = 32'h100;
        c1 = 1; st1 = 1; a1 = 32'h200;
        tick();
        total++; if (grant_o !== 2'b01) begin bad++; $display("FAIL tie_first: got %b want 01", grant_o); end
        settle();
        total++; if ({ack0, ack1} !== 2'b10) begin bad++; $display("FAIL tie_acks: got %b want 10", {ack0, ack1}); end
        total++; if (dsm1 !== 32'h0) begin bad++; $display("FAIL tie_dat_sm1: got %h want 0", dsm1); end
        tick();
        a0 = 32'h104;
        tick();
        c0 = 0; st0 = 0;
        tick();
        total++; if (grant_o !== 2'b10) begin bad++; $display("FAIL tie_handover: got %b want 10", grant_o); end
        settle();
        total++; if ({ack0, ack1} !== 2'b01) begin bad++; $display("FAIL tie_acks1: got %b want 01", {ack0, ack1}); end
        total++; if ({m_we, m_adr} !== {1'b1, 32'h200}) begin bad++; $display("FAIL tie_route1: got %b/%h want 1/200", m_we, m_adr); end
        tick();
        c1 = 0; st1 = 0;
        tick();
        total++; if (grant_o !== 2'b00) begin bad++; $display("FAIL tie_idle: got %b want 00", grant_o); end
    endtask

    task automatic test_preempt();
        c0 = 1; st0 = 1; a0 = 32'h300;
        tick();
        total++; if (grant_o !== 2'b01) begin bad++; $display("FAIL pre_grant0: got %b want 01", grant_o); end
        c1 = 1; st1 = 1; a1 = 32'h400;
        for (int k = 0; k < MAX_ACK; k++) begin
            settle();
            total++; if ({ack0, ack1} !== 2'b10) begin bad++; $display("FAIL pre_ack0[%0d]: got %b want 10", k, {ack0, ack1}); end
            tick();
            a0 = a0 + 4;
        end
        total++; if (grant_o !== 2'b10) begin bad++; $display("FAIL pre_switch: got %b want 10", grant_o); end
        settle();
        total++; if ({ack0, ack1} !== 2'b01) begin bad++; $display("FAIL pre_stall0: got %b want 01", {ack0, ack1}); end
        total++; if (m_adr !== 32'h400) begin bad++; $display("FAIL pre_adr1: got %h want 400", m_adr); end
        tick();
        c1 = 0; st1 = 0;
        settle();
        total++; if (ack0 !== 1'b0) begin bad++; $display("FAIL pre_stall0b: got %b want 0", ack0); end
        tick();
        total++; if (grant_o !== 2'b01) begin bad++; $display("FAIL pre_resume: got %b want 01", grant_o); end
        settle();
        total++; if ({ack0, m_adr} !== {1'b1, 32'h310}) begin bad++; $display("FAIL pre_resume_xfer: got %b/%h want 1/310", ack0, m_adr); end
        tick();
        c0 = 0; st0 = 0;
        tick();
        total++; if (grant_o !== 2'b00) begin bad++; $display("FAIL pre_idle: got %b want 00", grant_o); end
    endtask

    task automatic test_err();
        c1 = 1; st1 = 1; a1 = 32'h500;
        tick();
        total++; if (grant_o !== 2'b10) begin bad++; $display("FAIL err_grant1: got %b want 10", grant_o); end
        c0 = 1; st0 = 1; a0 = 32'h600;
        settle();
        total++; if (ack1 !== 1'b1) begin bad++; $display("FAIL err_first_ack: got %b want 1", ack1); end
        tick();
        a1 = 32'h504; err_on = 1;
        settle();
        total++; if ({err0, err1, ack1} !== 3'b010) begin bad++; $display("FAIL err_route: got %b want 010", {err0, err1, ack1}); end
        tick();
        err_on = 0;
        total++; if (dut.ack_cnt !== 3'd1) begin bad++; $display("FAIL err_count: got %0d want 1", dut.ack_cnt); end
        total++; if (grant_o !== 2'b10) begin bad++; $display("FAIL err_hold: got %b want 10", grant_o); end
        tick();
        c1 = 0; st1 = 0;
        total++; if (dut.ack_cnt !== 3'd2) begin bad++; $display("FAIL err_count2: got %0d want 2", dut.ack_cnt); end
        tick();
        total++; if (grant_o !== 2'b01) begin bad++; $display("FAIL err_handover: got %b want 01", grant_o); end
        c0 = 0; st0 = 0;
        tick();
    endtask

    task automatic test_reset_mid();
        c1 = 1; st1 = 1; a1 = 32'h700;
        tick();
        total++; if (grant_o !== 2'b10) begin bad++; $display("FAIL rmid_grant1: got %b want 10", grant_o); end
        tick();
        a1 = 32'h704;
        sys_rst = 1;
        settle();
        total++; if ({m_cyc, ack1} !== 2'b00) begin bad++; $display("FAIL rmid_drop: got %b want 00", {m_cyc, ack1}); end
        total++; if (grant_o !== 2'b00) begin bad++; $display("FAIL rmid_grant: got %b want 00", grant_o); end
        tick();
        sys_rst = 0;
        c0 = 1; st0 = 1; a0 = 32'h800;
        tick();
        total++; if (grant_o !== 2'b01) begin bad++; $display("FAIL rmid_tie: got %b want 01", grant_o); end
        settle();
        total++; if ({ack0, ack1} !== 2'b10) begin bad++; $display("FAIL rmid_acks: got %b want 10", {ack0, ack1}); end
        tick();
        c0 = 0; st0 = 0; c1 = 0; st1 = 0;
        tick();
        tick();
    endtask

    task automatic test_stress();
        int rem0 = 0, rem1 = 0, wait0 = 0, wait1 = 0;
        logic r0 = 0, r1 = 0, prev_busy = 0, prev_term = 0;
        logic [63:0] prev_bus = '0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            if (c0) begin
                if (r0) begin
                    a0 = a0 + 4; d0 = ~a0; rem0--;
                    if (rem0 == 0) begin c0 = 0; st0 = 0; end
                end
            end else if ($urandom_range(3) == 0) begin
                c0 = 1; st0 = 1; rem0 = $urandom_range(6, 1); a0 = $urandom & 32'hFFFF_FFFC; d0 = ~a0;
            end
            if (c1) begin
                if (r1) begin
                    a1 = a1 + 4; d1 = ~a1; rem1--;
                    if (rem1 == 0) begin c1 = 0; st1 = 0; end
                end
            end else if ($urandom_range(3) == 0) begin
                c1 = 1; st1 = 1; rem1 = $urandom_range(6, 1); a1 = $urandom & 32'hFFFF_FFFC; d1 = ~a1;
            end
            ack_en = ($urandom_range(3) != 0);
            settle();
            total++; if (ack0 && grant_o !== 2'b01) begin bad++; $display("FAIL stress_ack0 @%0d: grant %b with ack0", cyc, grant_o); end
            total++; if (ack1 && grant_o !== 2'b10) begin bad++; $display("FAIL stress_ack1 @%0d: grant %b with ack1", cyc, grant_o); end
            if (prev_busy && !prev_term && m_cyc && m_stb) begin
                total++;
                if ({m_adr, m_dat_ms} !== prev_bus) begin bad++; $display("FAIL stress_stable @%0d: got %h want %h", cyc, {m_adr, m_dat_ms}, prev_bus); end
            end
            if (!c0 || grant_o == 2'b01) wait0 = 0; else if (m_ack | m_err | m_rty) wait0++;
            if (!c1 || grant_o == 2'b10) wait1 = 0; else if (m_ack | m_err | m_rty) wait1++;
            total++; if (wait0 > 2 * MAX_ACK + 2) begin bad++; $display("FAIL stress_wait0 @%0d: got %0d want <=%0d", cyc, wait0, 2 * MAX_ACK + 2); end
            total++; if (wait1 > 2 * MAX_ACK + 2) begin bad++; $display("FAIL stress_wait1 @%0d: got %0d want <=%0d", cyc, wait1, 2 * MAX_ACK + 2); end
            r0 = ack0 | err0 | rty0;
            r1 = ack1 | err1 | rty1;
            prev_busy = m_cyc & m_stb;
            prev_term = m_ack | m_err | m_rty;
            prev_bus  = {m_adr, m_dat_ms};
            tick();
        end
        c0 = 0; st0 = 0; c1 = 0; st1 = 0; ack_en = 1;
        tick();
        tick();
        total++; if (grant_o !== 2'b00) begin bad++; $display("FAIL stress_idle: got %b want 00", grant_o); end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        sys_rst = 1; ack_en = 1; err_on = 0;
        c0 = 0; st0 = 0; we0 = 0; a0 = '0; d0 = '0; sel0 = 4'hF; cti0 = '0; bte0 = '0;
        c1 = 0; st1 = 0; we1 = 1; a1 = '0; d1 = 32'h1234_5678; sel1 = 4'hF; cti1 = '0; bte1 = '0;
        #2;
        test_reset();
        test_single_burst();
        test_tie();
        test_preempt();
        test_err();
        test_reset_mid();
        test_stress();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
